lcd_message_ctrl: RTL and testbench
===================================

# lcd_message_ctrl

Parametrised HD44780-style character-LCD controller; successor to the single-message `lcd_display` block. Holds a writable message buffer, runs the controller power-on init sequence once after reset, then streams the buffered message to the panel on each `start`, inserting a line-2 cursor command at the line boundary. Drives the LCD bus (`data`, `rs`, `rw`, `en`) with programmable setup, enable-pulse and settle timing, and reports `busy`/`done` to the host logic.

## Interface
- `MSG_LEN`, 32: buffer depth in characters (≥2)
- `LINE_LEN`, 16: characters per panel line; line-2 command inserted after this many characters
- `SETUP_CYCLES`, 1: cycles `rs`/`data` are stable before `en` rises (≥1)
- `EN_CYCLES`, 2: `en` high width (≥1)
- `WAIT_CYCLES`, 4: settle cycles after `en` falls, before the next transfer (≥1)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wr_en`  in  1  buffer write strobe
- `wr_addr`  in  $clog2(MSG_LEN)  buffer write address
- `wr_data`  in  8  ASCII character; 0x00 terminates the message
- `start`  in  1  single-cycle request to display the buffer
- `busy`  out  1  transfer sequence in progress
- `done`  out  1  one-cycle pulse at sequence end
- `data`  out  8  LCD data bus
- `rs`  out  1  0 = command, 1 = character
- `rw`  out  1  tied 0 (write only)
- `en`  out  1  LCD enable strobe

## Operation
- Reset (`reset` low): `data`=0x00, `rs`=0, `rw`=0, `en`=0, `busy`=0, `done`=0. All buffer entries are set to 0x00, `init_done` is cleared, and the FSM enters IDLE. Reset mid-sequence aborts immediately.
- Buffer: `wr_en` in IDLE writes `wr_data` to `wr_addr`. Writes are ignored while `busy`=1. Out-of-range `wr_addr` (≥MSG_LEN) is ignored.
- FSM states: IDLE → INIT (only if `init_done`=0) or CLEAR → CHAR ⇄ LINE2 → FIN → IDLE.
  - INIT sends commands 0x38, 0x0C, 0x01, 0x06, then sets `init_done` and goes to CHAR.
  - CLEAR sends 0x01 (used on every later `start`).
  - CHAR sends `buf[idx]` with `rs`=1 and increments `idx`. It stops on a 0x00 byte (not sent) or once `idx`=MSG_LEN.
  - LINE2: when `idx`=LINE_LEN and LINE_LEN<MSG_LEN, command 0xC0 (`rs`=0) is sent once before character LINE_LEN. This command is not sent if the character at LINE_LEN is 0x00.
- `start` is sampled only in IDLE. `start` while `busy` is ignored. `start` coincident with `wr_en` in IDLE: the write happens and the new value is displayed.
- Each byte transfer is SETUP → PULSE → HOLD, performed by the sub-module.

## Timing
- One 8-bit transfer takes T = SETUP_CYCLES+EN_CYCLES+WAIT_CYCLES cycles (default 7). `data`/`rs` stay stable through all three phases.
- `busy` rises the cycle after `start` is sampled and the first SETUP begins in that same cycle.
- `busy` falls in the cycle after the last HOLD cycle, and `done`=1 for exactly that cycle.
- start→done latency is 1 + T·N cycles, with N = number of bus transfers.
- Empty buffer (buf[0]=0x00): only init or clear is sent. With defaults this is N=4 on the first start and N=1 afterwards.
- Between transfers `en`=0; `data` holds its last value.

## Configuration
- `LCD_FOUR_BIT_EN` defined: 4-bit interface.
  - Each byte is sent as two transfers, high nibble first, on `data[7:4]`; `data[3:0]` is driven 0.
  - INIT first sends a single-nibble 0x2, and uses function set 0x28 instead of 0x38.
  - Transfers per byte = 2; the init sequence is 9 transfers.
- `LCD_FOUR_BIT_EN` undefined: 8-bit interface as described above.

## Structure
- Package `lcd_pkg`:
  - command constants: `LCD_CMD_FUNC8`=0x38, `LCD_CMD_FUNC4`=0x28, `LCD_CMD_DISP_ON`=0x0C, `LCD_CMD_CLEAR`=0x01, `LCD_CMD_ENTRY`=0x06, `LCD_CMD_LINE2`=0xC0
  - FSM state enum typedef
- Sub-module `lcd_bus_xfer`:
  - inputs: `req`, `byte_in`, `rs_in`, `nibble_mode`
  - outputs: `ack` (one-cycle pulse after HOLD), `data`, `rs`, `en`
  - owns the phase counters and nibble sequencing.

## Test plan
- Reset held low for 3 cycles, then released → all outputs 0, `busy`=0, and no `en` pulse for 20 idle cycles.
- Write "Hello World" at addresses 0–10 with 0x00 at 11, then `start` → bus sequence:
  - 0x38, 0x0C, 0x01, 0x06 with `rs`=0
  - then 0x48 0x65 0x6C 0x6C 0x6F 0x20 0x57 0x6F 0x72 0x6C 0x64 with `rs`=1
  - each `en` pulse exactly 2 cycles wide; `done` at 1+15·7=106 cycles after `start`.
- Second `start` with the same buffer → 0x01, then the 11 characters, and no re-init; `done` after 1+12·7=85 cycles.
- 20-character message with LINE_LEN=16 → 0xC0 (`rs`=0) appears between character 15 and character 16. A 16-character message ending in 0x00 produces no 0xC0.
- `start` and `wr_en` asserted mid-sequence → both ignored: byte stream unchanged, buffer unchanged.
- With `LCD_FOUR_BIT_EN` defined, 'H' → nibbles 0x4 then 0x8 on `data[7:4]` with `data[3:0]`=0. Reset asserted mid-PULSE drops `en` and `busy` immediately.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the character-LCD controller.
//   - HD44780 command bytes used by the init / clear / line-2 sequences
//   - top-level sequencer state enum and bus-transfer phase enum
//   - lcd_init_cmd(): byte for a given step of the power-on init sequence
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNC8   = 8'h38;
  localparam logic [7:0] LCD_CMD_FUNC4   = 8'h28;
  localparam logic [7:0] LCD_CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;
  // Lone nibble 0x2 that switches the panel into 4-bit mode; carried in the
  // high half so it lands on data[7:4].
  localparam logic [7:0] LCD_NIB_4BIT    = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_CLEAR,
    ST_CHAR,
    ST_LINE2,
    ST_FIN
  } lcd_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_PULSE,
    PH_HOLD
  } lcd_phase_e;

  // 8-bit init: FUNC8, DISP_ON, CLEAR, ENTRY (steps 0..3)
  // 4-bit init: nibble 0x2, FUNC4, DISP_ON, CLEAR, ENTRY (steps 0..4)
  function automatic logic [7:0] lcd_init_cmd(input logic [2:0] step,
                                              input logic       four_bit);
    logic [7:0] cmd;
    cmd = LCD_CMD_ENTRY;
    if (four_bit) begin
      case (step)
        3'd0:    cmd = LCD_NIB_4BIT;
        3'd1:    cmd = LCD_CMD_FUNC4;
        3'd2:    cmd = LCD_CMD_DISP_ON;
        3'd3:    cmd = LCD_CMD_CLEAR;
        default: cmd = LCD_CMD_ENTRY;
      endcase
    end else begin
      case (step)
        3'd0:    cmd = LCD_CMD_FUNC8;
        3'd1:    cmd = LCD_CMD_DISP_ON;
        3'd2:    cmd = LCD_CMD_CLEAR;
        default: cmd = LCD_CMD_ENTRY;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// lcd_bus_xfer: performs one LCD bus write as SETUP -> PULSE -> HOLD.
//   clk, rst_n      clock / async active-low reset
//   req             start a transfer (taken when idle or in the final HOLD
//                   cycle, so back-to-back transfers have no gap)
//   byte_in, rs_in  byte and register select to send
//   nibble_mode     1: send byte as two transfers, high nibble first, on
//                   data[7:4] with data[3:0]=0; 0: send byte_in as-is
//   ack             high during the final HOLD cycle of the whole byte; the
//                   transfer completes at the following clock edge
//   data, rs, en    registered LCD bus outputs
module lcd_bus_xfer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 2,
  parameter int WAIT_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] byte_in,
  input  logic       rs_in,
  input  logic       nibble_mode,
  output logic       ack,
  output logic [7:0] data,
  output logic       rs,
  output logic       en
);

  localparam int MAX_A = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_C = (MAX_A > WAIT_CYCLES) ? MAX_A : WAIT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] E_LAST = CW'(EN_CYCLES - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WAIT_CYCLES - 1);

  lcd_phase_e    phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          en_q, en_d;
  logic          second_q, second_d;  // low nibble still to go
  logic [3:0]    lo_q, lo_d;
  logic          last_hold;
  logic          accept;

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    rs_d      = rs_q;
    second_d  = second_q;
    lo_d      = lo_q;
    last_hold = (phase_q == PH_HOLD) && (cnt_q == W_LAST);
    ack       = last_hold && !second_q;
    accept    = req && ((phase_q == PH_IDLE) || ack);

    case (phase_q)
      PH_SETUP: begin
        if (cnt_q == S_LAST) begin
          phase_d = PH_PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PH_PULSE: begin
        if (cnt_q == E_LAST) begin
          phase_d = PH_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PH_HOLD: begin
        if (!last_hold) begin
          cnt_d = cnt_q + CW'(1);
        end else if (second_q) begin
          phase_d  = PH_SETUP;
          cnt_d    = '0;
          data_d   = {lo_q, 4'h0};
          second_d = 1'b0;
        end else begin
          phase_d = PH_IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase

    // A new request overrides the return to idle at the end of HOLD.
    if (accept) begin
      phase_d  = PH_SETUP;
      cnt_d    = '0;
      rs_d     = rs_in;
      data_d   = nibble_mode ? {byte_in[7:4], 4'h0} : byte_in;
      lo_d     = byte_in[3:0];
      second_d = nibble_mode;
    end

    en_d = (phase_d == PH_PULSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      second_q <= 1'b0;
      lo_q     <= '0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
      second_q <= second_d;
      lo_q     <= lo_d;
    end
  end

  assign data = data_q;
  assign rs   = rs_q;
  assign en   = en_q;

endmodule

// File: rtl/lcd_message_ctrl.sv
// lcd_message_ctrl: HD44780-style character LCD controller with a writable
// message buffer. First start after reset runs the init sequence, later
// starts send CLEAR; then the buffer is streamed up to the first 0x00 or
// MSG_LEN characters, with a line-2 cursor command before char LINE_LEN.
//   clk, reset         clock / async active-low reset
//   wr_en/addr/data    buffer write port (honoured only in IDLE)
//   start              display request (sampled only in IDLE)
//   busy, done         sequence in progress / one-cycle end pulse
//   data, rs, rw, en   LCD bus (rw tied 0)
// Build option: LCD_FOUR_BIT_EN selects the 4-bit bus interface.
module lcd_message_ctrl
  import lcd_pkg::*;
#(
  parameter int MSG_LEN      = 32,
  parameter int LINE_LEN     = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 2,
  parameter int WAIT_CYCLES  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 data,
  output logic                       rs,
  output logic                       rw,
  output logic                       en
);

  localparam int AW = $clog2(MSG_LEN);
  localparam int IW = $clog2(MSG_LEN + 1);

`ifdef LCD_FOUR_BIT_EN
  localparam logic       FOUR_BIT  = 1'b1;
  localparam logic [2:0] INIT_LAST = 3'd4;
`else
  localparam logic       FOUR_BIT  = 1'b0;
  localparam logic [2:0] INIT_LAST = 3'd3;
`endif

  localparam logic [IW-1:0] IDX_END = IW'(MSG_LEN);
  localparam logic [IW-1:0] IDX_L2  = IW'(LINE_LEN);
  localparam logic          HAS_L2  = (LINE_LEN < MSG_LEN);

  lcd_state_e    state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [IW-1:0] idx_q, idx_d;     // next character to send
  logic          init_done_q, init_done_d;
  logic [7:0]    buf_q [MSG_LEN];

  logic          wr_ok;
  logic [7:0]    cur_char;
  logic          advance;
  logic          x_req, x_rs, x_nib, x_ack;
  logic [7:0]    x_byte;

  assign wr_ok    = wr_en && (state_q == ST_IDLE) && (int'(wr_addr) < MSG_LEN);
  assign cur_char = (idx_q < IDX_END) ? buf_q[idx_q[AW-1:0]] : 8'h00;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    x_req       = 1'b0;
    x_byte      = 8'h00;
    x_rs        = 1'b0;
    x_nib       = FOUR_BIT;
    advance     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d = '0;
          x_req = 1'b1;
          if (!init_done_q) begin
            state_d = ST_INIT;
            step_d  = 3'd0;
            x_byte  = lcd_init_cmd(3'd0, FOUR_BIT);
            x_nib   = 1'b0;  // 8-bit: plain byte; 4-bit: lone 0x2 nibble
          end else begin
            state_d = ST_CLEAR;
            x_byte  = LCD_CMD_CLEAR;
          end
        end
      end
      ST_INIT: begin
        if (x_ack) begin
          if (step_q == INIT_LAST) begin
            init_done_d = 1'b1;
            advance     = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
            x_req  = 1'b1;
            x_byte = lcd_init_cmd(step_q + 3'd1, FOUR_BIT);
          end
        end
      end
      ST_CLEAR, ST_CHAR: begin
        if (x_ack) advance = 1'b1;
      end
      ST_LINE2: begin
        // Character at LINE_LEN was seen non-zero before 0xC0 was issued.
        if (x_ack) begin
          state_d = ST_CHAR;
          x_req   = 1'b1;
          x_byte  = cur_char;
          x_rs    = 1'b1;
          idx_d   = idx_q + IW'(1);
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pick the next item of the character phase once the previous
    // transfer completes; the line-2 test only sees idx==LINE_LEN here
    // before that character has been sent.
    if (advance) begin
      if ((idx_q == IDX_END) || (cur_char == 8'h00)) begin
        state_d = ST_FIN;
      end else if (HAS_L2 && (idx_q == IDX_L2)) begin
        state_d = ST_LINE2;
        x_req   = 1'b1;
        x_byte  = LCD_CMD_LINE2;
      end else begin
        state_d = ST_CHAR;
        x_req   = 1'b1;
        x_byte  = cur_char;
        x_rs    = 1'b1;
        idx_d   = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) buf_q[i] <= 8'h00;
    end else if (wr_ok) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  lcd_bus_xfer #(
    .SETUP_CYCLES (SETUP_CYCLES),
    .EN_CYCLES    (EN_CYCLES),
    .WAIT_CYCLES  (WAIT_CYCLES)
  ) u_xfer (
    .clk         (clk),
    .rst_n       (reset),
    .req         (x_req),
    .byte_in     (x_byte),
    .rs_in       (x_rs),
    .nibble_mode (x_nib),
    .ack         (x_ack),
    .data        (data),
    .rs          (rs),
    .en          (en)
  );

  assign busy = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done = (state_q == ST_FIN);
  assign rw   = 1'b0;

endmodule

// File: tb/tb_lcd_message_ctrl.sv
// Scoreboard bench for lcd_message_ctrl: expected bus bytes are queued when a
// start is issued and popped on every rising edge of en.
module tb_lcd_message_ctrl;

  localparam int MSG_LEN  = 32;
  localparam int LINE_LEN = 16;
  localparam int SC = 1, EC = 2, WC = 4;
  localparam int T  = SC + EC + WC;
  localparam int AW = $clog2(MSG_LEN);

  logic          clk = 1'b0, reset = 1'b0, wr_en = 1'b0, start = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          busy, done, rs, rw, en;
  logic [7:0]    data;

  always #5 clk = ~clk;

  lcd_message_ctrl #(
    .MSG_LEN(MSG_LEN), .LINE_LEN(LINE_LEN),
    .SETUP_CYCLES(SC), .EN_CYCLES(EC), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .data(data), .rs(rs), .rw(rw), .en(en)
  );

  int         n_chk = 0, n_fail = 0;
  logic [9:0] sb[$];           // {valid, rs, data}
  logic [7:0] mdl[MSG_LEN];
  bit         idone = 1'b0, mon_on = 1'b1, en_prev = 1'b0;
  int         en_wid = 0, n_rise = 0, nx = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // bus monitor
  always @(negedge clk) begin
    logic [9:0] e;
    if (!mon_on) begin
      en_prev = 1'b0;
      en_wid  = 0;
    end else begin
      if (en && !en_prev) begin
        n_rise++;
        e = 10'h0;
        if (sb.size() > 0) e = sb.pop_front();
        chk("bus", {1'b1, rs, data}, e);
        chk("rw", rw, 0);
      end
      if (en) en_wid++;
      else if (en_prev) begin
        chk("en_width", en_wid, EC);
        en_wid = 0;
      end
      en_prev = en;
    end
  end

  task automatic push_b(input logic [7:0] b, input logic r);
`ifdef LCD_FOUR_BIT_EN
    sb.push_back({1'b1, r, b[7:4], 4'h0});
    sb.push_back({1'b1, r, b[3:0], 4'h0});
    nx += 2;
`else
    sb.push_back({1'b1, r, b});
    nx += 1;
`endif
  endtask

  task automatic push_seq();
    nx = 0;
    if (!idone) begin
`ifdef LCD_FOUR_BIT_EN
      sb.push_back({2'b10, 8'h20});
      nx = 1;
      push_b(8'h28, 1'b0);
`else
      push_b(8'h38, 1'b0);
`endif
      push_b(8'h0C, 1'b0);
      push_b(8'h01, 1'b0);
      push_b(8'h06, 1'b0);
      idone = 1'b1;
    end else begin
      push_b(8'h01, 1'b0);
    end
    for (int i = 0; i < MSG_LEN; i++) begin
      if (mdl[i] == 8'h00) break;
      if (i == LINE_LEN && LINE_LEN < MSG_LEN) push_b(8'hC0, 1'b0);
      push_b(mdl[i], 1'b1);
    end
  endtask

  // called at a negedge; returns at a negedge
  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mdl[a] = d;
  endtask

  // poke>0: fire start+wr_en(addr 0) at that cycle mid-sequence
  task automatic run(input string tag, input int poke);
    int  cnt;
    bit  got;
    push_seq();
    start = 1'b1;
    cnt = 0; got = 1'b0;
    while (cnt < 3000 && !got) begin
      @(negedge clk);
      cnt++;
      start = 1'b0; wr_en = 1'b0;
      if (cnt == 1) chk({tag, "_busy"}, busy, 1);
      if (poke > 0 && cnt == poke) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 8'h5A;
      end
      if (done) got = 1'b1;
    end
    chk({tag, "_lat"}, cnt, 1 + T * nx);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {done, busy}, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    string s;
    int    cnt;
    s = "Hello World";
    for (int i = 0; i < MSG_LEN; i++) mdl[i] = 8'h00;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", {data, rs, rw, en, busy, done}, 0);
    reset = 1'b1;
    n_rise = 0;
    repeat (20) @(negedge clk);
    chk("idle_en", n_rise, 0);
    chk("idle_out", {busy, done, en}, 0);

    for (int i = 0; i < 11; i++) wr(i, s[i]);
    wr(11, 8'h00);
    run("hello", 0);
    run("again", 0);

    for (int i = 0; i < 20; i++) wr(i, 8'h41 + 8'(i));
    wr(20, 8'h00);
    run("line2", 0);
    wr(16, 8'h00);
    run("len16", 0);
    run("poke", 30);
    run("after_poke", 0);

    // reset in the middle of an en pulse
    push_seq();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!en && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("saw_en", en, 1);
    mon_on = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    idone = 1'b0;
    for (int i = 0; i < MSG_LEN; i++) mdl[i] = 8'h00;
    mon_on = 1'b1;

    run("empty_init", 0);
    run("empty_clr", 0);

    // write coincident with start in IDLE is displayed
    wr_en = 1'b1; wr_addr = '0; wr_data = 8'h51; mdl[0] = 8'h51;
    run("coinc", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
